// File: rtl/clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_gen
// Purpose  : Free-running divider producing a 50% duty slow clock plus
//            single-cycle rising/falling edge strobes, all registered.
// Revision : 1.0
// ============================================================================
module clk_gen #(
    parameter longint MAIN_CLK_HZ = 50_000_000,
    parameter longint CLK_HZ      = 10_000,
    parameter bit     CLK_INIT    = 1'b1
) (
    input  logic in_clk,
    input  logic in_rst,
    output logic out_clk,
    output logic out_clk_re,
    output logic out_clk_fe
);

    // Guard the division so an illegal parameter set reaches the error below
    localparam longint HALF_RAW = (CLK_HZ > 0 && MAIN_CLK_HZ > 0) ?
                                  MAIN_CLK_HZ / (2 * CLK_HZ) : 64'sd1;
    localparam longint HALF     = (HALF_RAW < 1) ? 64'sd1 : HALF_RAW;
    localparam int     CNT_W    = $clog2(HALF) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

    generate
        if (CLK_HZ <= 0 || MAIN_CLK_HZ <= 0) begin : g_bad_param
            $error("clk_gen: CLK_HZ and MAIN_CLK_HZ must both be positive");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             re_q, re_d;
    logic             fe_q, fe_d;
    logic             toggle;

    always_comb begin
        toggle = (cnt_q == CNT_LAST);
        cnt_d  = toggle ? '0 : cnt_q + CNT_W'(1);
        clk_d  = toggle ? ~clk_q : clk_q;
        // Strobes land in the same cycle as the new out_clk level
        re_d   = toggle & ~clk_q;
        fe_d   = toggle &  clk_q;
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            cnt_q <= '0;
            clk_q <= CLK_INIT;
            re_q  <= 1'b0;
            fe_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
            re_q  <= re_d;
            fe_q  <= fe_d;
        end
    end

    assign out_clk    = clk_q;
    assign out_clk_re = re_q;
    assign out_clk_fe = fe_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_gen
// Purpose  : Self-checking bench for clk_gen across four divider configs.
// Revision : 1.0
// ============================================================================
module tb_clk_gen;

    localparam int N_INST = 4;

    typedef struct {
        int   n;
        logic clk;
        logic re;
        logic fe;
    } vec_t;

    typedef struct {
        int         id;
        logic [2:0] exp;   // {out_clk, out_clk_re, out_clk_fe}
    } sb_t;

    logic clk;
    logic rst_n;
    logic oc  [N_INST];
    logic ore [N_INST];
    logic ofe [N_INST];

    int   n_cmp;
    int   n_err;
    sb_t  sbq[$];

    // Expected divider settings: 100/(2*10)=5, 100/(2*60)=0->1, 100/(2*15)=3
    int   halfv [N_INST] = '{5, 5, 1, 3};
    logic initv [N_INST] = '{1'b1, 1'b0, 1'b1, 1'b1};

    clk_gen #(.MAIN_CLK_HZ(100), .CLK_HZ(10), .CLK_INIT(1'b1)) u_a (
        .in_clk(clk), .in_rst(rst_n), .out_clk(oc[0]), .out_clk_re(ore[0]), .out_clk_fe(ofe[0]));
    clk_gen #(.MAIN_CLK_HZ(100), .CLK_HZ(10), .CLK_INIT(1'b0)) u_b (
        .in_clk(clk), .in_rst(rst_n), .out_clk(oc[1]), .out_clk_re(ore[1]), .out_clk_fe(ofe[1]));
    clk_gen #(.MAIN_CLK_HZ(100), .CLK_HZ(60), .CLK_INIT(1'b1)) u_c (
        .in_clk(clk), .in_rst(rst_n), .out_clk(oc[2]), .out_clk_re(ore[2]), .out_clk_fe(ofe[2]));
    clk_gen #(.MAIN_CLK_HZ(100), .CLK_HZ(15), .CLK_INIT(1'b1)) u_d (
        .in_clk(clk), .in_rst(rst_n), .out_clk(oc[3]), .out_clk_re(ore[3]), .out_clk_fe(ofe[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // n = rising edges since reset release
    function automatic logic [2:0] model(int half, logic init, int n);
        int   t;
        logic c;
        logic tog;
        t   = n / half;
        c   = init ^ t[0];
        tog = (n > 0) && (n % half == 0);
        return {c, tog & c, tog & ~c};
    endfunction

    function automatic logic [2:0] actual(int id);
        return {oc[id], ore[id], ofe[id]};
    endfunction

    task automatic chk(string name, int id, logic [2:0] act, logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst=%0d t=%0t actual={clk,re,fe}=%b required=%b",
                     name, id, $time, act, exp);
        end
    endtask

    task automatic chk_reset(string name);
        for (int i = 0; i < N_INST; i++)
            chk(name, i, actual(i), {initv[i], 2'b00});
    endtask

    // Push model expectations at the edge, pop and compare at the following negedge
    task automatic run_edges(int first, int last, string name);
        sb_t e;
        for (int n = first; n <= last; n++) begin
            @(posedge clk);
            for (int i = 0; i < N_INST; i++) begin
                e.id  = i;
                e.exp = model(halfv[i], initv[i], n);
                sbq.push_back(e);
            end
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk(name, e.id, actual(e.id), e.exp);
            end
        end
    endtask

    initial begin
        vec_t tbl [12];
        sb_t  e;
        int   cnt_re;
        int   cnt_fe;
        int   both;

        tbl[0]  = '{1,  1'b1, 1'b0, 1'b0};
        tbl[1]  = '{2,  1'b1, 1'b0, 1'b0};
        tbl[2]  = '{3,  1'b1, 1'b0, 1'b0};
        tbl[3]  = '{4,  1'b1, 1'b0, 1'b0};
        tbl[4]  = '{5,  1'b0, 1'b0, 1'b1};
        tbl[5]  = '{6,  1'b0, 1'b0, 1'b0};
        tbl[6]  = '{7,  1'b0, 1'b0, 1'b0};
        tbl[7]  = '{8,  1'b0, 1'b0, 1'b0};
        tbl[8]  = '{9,  1'b0, 1'b0, 1'b0};
        tbl[9]  = '{10, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{11, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{12, 1'b1, 1'b0, 1'b0};

        n_cmp  = 0;
        n_err  = 0;
        cnt_re = 0;
        cnt_fe = 0;
        both   = 0;
        rst_n  = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset("reset_hold");

        rst_n = 1'b1;
        // Table vectors for the HALF=5/INIT=1 instance, model for the others
        foreach (tbl[k]) begin
            @(posedge clk);
            e.id  = 0;
            e.exp = {tbl[k].clk, tbl[k].re, tbl[k].fe};
            sbq.push_back(e);
            for (int i = 1; i < N_INST; i++) begin
                e.id  = i;
                e.exp = model(halfv[i], initv[i], tbl[k].n);
                sbq.push_back(e);
            end
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("table", e.id, actual(e.id), e.exp);
            end
            if (ore[0]) cnt_re++;
            if (ofe[0]) cnt_fe++;
        end

        for (int n = 13; n <= 100; n++) begin
            @(posedge clk);
            for (int i = 0; i < N_INST; i++) begin
                e.id  = i;
                e.exp = model(halfv[i], initv[i], n);
                sbq.push_back(e);
            end
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("run", e.id, actual(e.id), e.exp);
            end
            if (ore[0]) cnt_re++;
            if (ofe[0]) cnt_fe++;
            for (int i = 0; i < N_INST; i++)
                if (ore[i] && ofe[i]) both++;
        end
        chk("re_count_100", 0, 3'(cnt_re), 3'(0) | 3'(cnt_re == 10 ? cnt_re : 10));
        n_cmp++;
        if (cnt_re != 10) begin
            n_err++;
            $display("FAIL re_count actual=%0d required=10", cnt_re);
        end
        n_cmp++;
        if (cnt_fe != 10) begin
            n_err++;
            $display("FAIL fe_count actual=%0d required=10", cnt_fe);
        end
        n_cmp++;
        if (both != 0) begin
            n_err++;
            $display("FAIL strobe_overlap actual=%0d required=0", both);
        end

        // Restart, run 7 edges, then drop reset between edges
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("reset_again");
        rst_n = 1'b1;
        run_edges(1, 7, "pre_async");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("async_assert");
        @(negedge clk);
        chk_reset("async_held");
        rst_n = 1'b1;
        run_edges(1, 12, "after_async");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
